// File: rtl/video_timing.sv
// Raster timing generator: walks h/v counters through active/porch/sync and
// registers colour, syncs, data-enable and frame_start so they stay aligned.
module video_timing #(
    parameter int   HOR_ACTIVE_PIXELS = 640,
    parameter int   HOR_FRONT_PORCH   = 16,
    parameter int   HOR_SYNC_PULSE    = 96,
    parameter int   HOR_BACK_PORCH    = 48,
    parameter int   VER_ACTIVE_PIXELS = 480,
    parameter int   VER_FRONT_PORCH   = 10,
    parameter int   VER_SYNC_PULSE    = 2,
    parameter int   VER_BACK_PORCH    = 33,
    parameter logic HSYNC_POLARITY    = 1'b0,
    parameter logic VSYNC_POLARITY    = 1'b0,
    localparam int  H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH,
    localparam int  V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH,
    localparam int  XW = (HOR_ACTIVE_PIXELS > 1) ? $clog2(HOR_ACTIVE_PIXELS) : 1,
    localparam int  YW = (VER_ACTIVE_PIXELS > 1) ? $clog2(VER_ACTIVE_PIXELS) : 1,
    localparam int  HW = $clog2(H_TOTAL),
    localparam int  VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    input  logic [7:0]    r_in,
    input  logic [7:0]    g_in,
    input  logic [7:0]    b_in,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_ACT_END  = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(VER_ACTIVE_PIXELS);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [7:0]    r_red, r_grn, r_blu;
    logic          r_de, r_hsync, r_vsync, r_frame_start;

    logic w_h_last, w_v_last, w_h_act, w_v_act, w_h_sync_on, w_v_sync_on;
    logic w_active, w_origin;

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_h_act     = (r_h_cnt < H_ACT_END);
    assign w_v_act     = (r_v_cnt < V_ACT_END);
    assign w_h_sync_on = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_v_sync_on = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
    assign w_active    = w_h_act && w_v_act;
    assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (ce) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Coordinates park at 0 in blanking so the pixel source never sees out-of-range values.
    assign x = w_h_act ? r_h_cnt[XW-1:0] : '0;
    assign y = w_v_act ? r_v_cnt[YW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red         <= '0;
            r_grn         <= '0;
            r_blu         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~HSYNC_POLARITY;
            r_vsync       <= ~VSYNC_POLARITY;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_red         <= w_active ? r_in : '0;
            r_grn         <= w_active ? g_in : '0;
            r_blu         <= w_active ? b_in : '0;
            r_de          <= w_active;
            r_hsync       <= w_h_sync_on ? HSYNC_POLARITY : ~HSYNC_POLARITY;
            r_vsync       <= w_v_sync_on ? VSYNC_POLARITY : ~VSYNC_POLARITY;
            r_frame_start <= w_origin;
        end
    end

    assign r           = r_red;
    assign g           = r_grn;
    assign b           = r_blu;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-parameter instance and a small one, both
// checked every clock against an arithmetic raster model (position = ce-edge count).
module tb_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instance A: default timing, active-low syncs
    logic       rst_a, ce_a, mode_a;
    logic [9:0] xa;
    logic [8:0] ya;
    logic [7:0] ra_in, ga_in, ba_in, ra, ga, ba;
    logic       hs_a, vs_a, de_a, fs_a;

    assign ra_in = mode_a ? 8'hFF : xa[7:0];
    assign ga_in = mode_a ? 8'hFF : ya[7:0];
    assign ba_in = mode_a ? 8'hFF : 8'hA5;

    video_timing dut_a (
        .clk(clk), .rst_n(rst_a), .ce(ce_a), .x(xa), .y(ya),
        .r_in(ra_in), .g_in(ga_in), .b_in(ba_in), .r(ra), .g(ga), .b(ba),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .frame_start(fs_a)
    );

    // ---------------- instance B: 8/1/2/1 x 4/1/1/1, active-high syncs
    logic       rst_b, ce_b, mode_b;
    logic [2:0] xb;
    logic [1:0] yb;
    logic [7:0] rb_in, gb_in, bb_in, rb, gb, bb;
    logic       hs_b, vs_b, de_b, fs_b;

    assign rb_in = mode_b ? 8'hFF : {5'b0, xb};
    assign gb_in = mode_b ? 8'hFF : {6'b0, yb};
    assign bb_in = mode_b ? 8'hFF : 8'hA5;

    video_timing #(
        .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(1), .HOR_SYNC_PULSE(2), .HOR_BACK_PORCH(1),
        .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC_PULSE(1), .VER_BACK_PORCH(1),
        .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .ce(ce_b), .x(xb), .y(yb),
        .r_in(rb_in), .g_in(gb_in), .b_in(bb_in), .r(rb), .g(gb), .b(bb),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame_start(fs_b)
    );

    // ---------------- reference model
    typedef struct {
        int h;
        int v;
        bit hact;
        bit vact;
        bit hs_on;
        bit vs_on;
        bit origin;
    } pos_t;

    typedef struct {
        logic [7:0] r, g, b;
        bit de, hs, vs, fs;
    } out_t;

    function automatic pos_t decode(input int n, input int ha, input int hf, input int hsw, input int hb,
                                    input int va, input int vf, input int vsw, input int vb);
        pos_t p;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int q  = n % (ht * vt);
        p.h      = q % ht;
        p.v      = q / ht;
        p.hact   = p.h < ha;
        p.vact   = p.v < va;
        p.hs_on  = (p.h >= ha + hf) && (p.h < ha + hf + hsw);
        p.vs_on  = (p.v >= va + vf) && (p.v < va + vf + vsw);
        p.origin = (q == 0);
        return p;
    endfunction

    function automatic pos_t pos_a(input int n);
        return decode(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic pos_t pos_b(input int n);
        return decode(n, 8, 1, 2, 1, 4, 1, 1, 1);
    endfunction

    // What the output register should hold after registering pixel p.
    function automatic out_t registered(input pos_t p, input bit flood, input bit hpol, input bit vpol);
        out_t o;
        bit act = p.hact && p.vact;
        o.r  = !act ? 8'h00 : (flood ? 8'hFF : 8'(p.h));
        o.g  = !act ? 8'h00 : (flood ? 8'hFF : 8'(p.v));
        o.b  = !act ? 8'h00 : (flood ? 8'hFF : 8'hA5);
        o.de = act;
        o.hs = p.hs_on ? hpol : !hpol;
        o.vs = p.vs_on ? vpol : !vpol;
        o.fs = p.origin;
        return o;
    endfunction

    function automatic out_t reset_out(input bit hpol, input bit vpol);
        out_t o;
        o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
        o.de = 1'b0; o.hs = !hpol; o.vs = !vpol; o.fs = 1'b0;
        return o;
    endfunction

    int   na, nb;
    out_t ea, eb;

    task automatic check_a();
        pos_t p = pos_a(na);
        check("a.x", 32'(xa), p.hact ? p.h : 0);
        check("a.y", 32'(ya), p.vact ? p.v : 0);
        check("a.r", 32'(ra), 32'(ea.r));
        check("a.g", 32'(ga), 32'(ea.g));
        check("a.b", 32'(ba), 32'(ea.b));
        check("a.de", 32'(de_a), 32'(ea.de));
        check("a.hsync", 32'(hs_a), 32'(ea.hs));
        check("a.vsync", 32'(vs_a), 32'(ea.vs));
        check("a.frame_start", 32'(fs_a), 32'(ea.fs));
    endtask

    task automatic check_b();
        pos_t p = pos_b(nb);
        check("b.x", 32'(xb), p.hact ? p.h : 0);
        check("b.y", 32'(yb), p.vact ? p.v : 0);
        check("b.r", 32'(rb), 32'(eb.r));
        check("b.g", 32'(gb), 32'(eb.g));
        check("b.b", 32'(bb), 32'(eb.b));
        check("b.de", 32'(de_b), 32'(eb.de));
        check("b.hsync", 32'(hs_b), 32'(eb.hs));
        check("b.vsync", 32'(vs_b), 32'(eb.vs));
        check("b.frame_start", 32'(fs_b), 32'(eb.fs));
    endtask

    // One clock: advance the model on the edge, then compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst_a) begin
            na = 0; ea = reset_out(1'b0, 1'b0);
        end else if (ce_a) begin
            ea = registered(pos_a(na), mode_a, 1'b0, 1'b0);
            na++;
        end
        if (!rst_b) begin
            nb = 0; eb = reset_out(1'b1, 1'b1);
        end else if (ce_b) begin
            eb = registered(pos_b(nb), mode_b, 1'b1, 1'b1);
            nb++;
        end
        #1;
        check_a();
        check_b();
    endtask

    int de_cnt, hs_cnt, hs_first, fs_cnt, hb_cnt, vb_cnt, clk_idx;
    int rises[$];
    int fs_at[$];
    bit prev_de, reached;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b1; ce_b = 1'b1; mode_a = 1'b0; mode_b = 1'b0;
        na = 0; nb = 0;
        ea = reset_out(1'b0, 1'b0);
        eb = reset_out(1'b1, 1'b1);

        // Reset held with ce=1: outputs stay at reset values.
        repeat (3) tick();
        #2 rst_a = 1'b1; rst_b = 1'b1;

        // Full-rate lines on A, random ce on B, random flood-white pixel source.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; fs_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            ce_b   = 1'($urandom_range(0, 1));
            mode_a = ($urandom_range(0, 7) == 0);
            mode_b = ($urandom_range(0, 3) == 0);
            tick();
            if (fs_a) fs_cnt++;
            if (na >= 1 && na <= 800) begin
                if (de_a) de_cnt++;
                if (!hs_a) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = na - 1;
                end
            end
        end
        check("a.line_de_width", de_cnt, 640);
        check("a.hsync_width", hs_cnt, 96);
        check("a.hsync_offset", hs_first, 656);
        check("a.frame_start_once", fs_cnt, 1);

        // Half-rate ce on A: a line must take 1600 clocks.
        prev_de = de_a;
        clk_idx = 0;
        for (int i = 0; i < 3400; i++) begin
            ce_a   = (i % 2 == 0);
            ce_b   = 1'($urandom_range(0, 1));
            mode_a = ($urandom_range(0, 7) == 0);
            mode_b = ($urandom_range(0, 3) == 0);
            tick();
            clk_idx++;
            if (de_a && !prev_de) rises.push_back(clk_idx);
            prev_de = de_a;
        end
        check("a.ce_half_rises", 32'(rises.size() >= 2), 1);
        if (rises.size() >= 2) check("a.ce_half_line_clks", rises[1] - rises[0], 1600);
        ce_a = 1'b1;

        // Run B to h_cnt=5, v_cnt=2, then reset it mid-cycle.
        ce_b = 1'b1; mode_b = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            tick();
            if (nb % 84 == 29) reached = 1'b1;
        end
        check("b.reached_midframe", 32'(reached), 1);
        #2 rst_b = 1'b0;
        #1;
        nb = 0;
        eb = reset_out(1'b1, 1'b1);
        check_b();
        repeat (2) tick();
        #2 rst_b = 1'b1;

        // Three frames of B after restart: sync widths and frame_start period.
        hb_cnt = 0; vb_cnt = 0;
        for (int i = 0; i < 252; i++) begin
            mode_b = ($urandom_range(0, 3) == 0);
            tick();
            if (i < 84) begin
                if (hs_b) hb_cnt++;
                if (vs_b) vb_cnt++;
            end
            if (fs_b) fs_at.push_back(i);
        end
        check("b.hsync_high_per_frame", hb_cnt, 14);
        check("b.vsync_high_per_frame", vb_cnt, 12);
        check("b.frame_start_count", fs_at.size(), 3);
        if (fs_at.size() >= 2) begin
            check("b.first_frame_start", fs_at[0], 0);
            check("b.frame_period", fs_at[1] - fs_at[0], 84);
        end

        // Random ce on both instances to finish.
        for (int i = 0; i < 600; i++) begin
            ce_a   = 1'($urandom_range(0, 1));
            ce_b   = 1'($urandom_range(0, 1));
            mode_a = ($urandom_range(0, 3) == 0);
            mode_b = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
